csr_trap_unit: RTL and testbench
================================

Name: csr_trap_unit

Overview:
Parametrised machine-mode CSR file with trap sequencing for the core. It provides:
- Zicsr read/modify/write.
- 64-bit mcycle/minstret counters.
- mstatus MIE/MPIE stacking on trap entry and MRET.
- Interrupt pending/enable gating.
- Trap-vector generation.

It sits between decode/execute (CSR ops) and the fetch unit (redirect on trap/MRET).

Parameters:
XLEN, 32, data width of all CSRs (32 only; counters split lo/hi)
HART_ID, 0, constant returned by mhartid
MISA_VAL, 32'h4000_0100, constant returned by misa (RV32I)
MTVEC_RESET, 32'h0000_0000, reset value of mtvec

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
csr_addr_i  in  12  CSR address
csr_op_i  in  2  00 none, 01 RW, 10 RS (set), 11 RC (clear)
csr_wdata_i  in  XLEN  operand (rs1/zimm)
csr_rdata_o  out  XLEN  old CSR value, combinational
csr_illegal_o  out  1  access to an unimplemented CSR, or write to a read-only CSR
instret_i  in  1  one instruction retired this cycle
trap_i  in  1  synchronous exception request (one-cycle pulse)
trap_cause_i  in  XLEN  exception cause code
trap_pc_i  in  XLEN  PC of the faulting instruction
mret_i  in  1  MRET executed (one-cycle pulse)
irq_ext_i  in  1  external interrupt level
irq_timer_i  in  1  timer interrupt level
irq_take_o  out  1  an interrupt is enabled and pending; pipeline must raise a trap
redirect_o  out  1  one-cycle pulse: fetch must jump to redirect_pc_o
redirect_pc_o  out  XLEN  trap vector or mepc

Behaviour:
Implemented CSRs:
- misa 0x301 (RO)
- mvendorid 0xF11 (RO, 0)
- marchid 0xF12 (RO, 0)
- mimpid 0xF13 (RO, 0)
- mhartid 0xF14 (RO, HART_ID)
- mstatus 0x300: only MIE bit3 and MPIE bit7 are writable; all other bits read 0.
- mie 0x304: MEIE bit11 and MTIE bit7 are writable.
- mtvec 0x305
- mcounteren 0x306
- mepc 0x341: bits[1:0] are forced to 0.
- mcause 0x342
- mip 0x344: read-only; MEIP bit11 = irq_ext_i, MTIP bit7 = irq_timer_i.
- mcycle 0xB00, mcycleh 0xB80
- minstret 0xB02, minstreth 0xB82

Reset values: all registers 0 except mtvec = MTVEC_RESET. Outputs redirect_o=0, irq_take_o=0, redirect_pc_o=0.

CSR access:
- Read is combinational.
- Write data is wdata (RW), old|wdata (RS), or old&~wdata (RC). It is committed on the next clock edge.
- RS/RC with wdata==0 do not write and never flag illegal.
- Illegal means: the address is not listed, or a write is attempted when addr[11:10]==2'b11.
- An illegal access commits nothing, and csr_rdata_o is 0.

Counters:
- mcycle increments every cycle.
- minstret increments when instret_i=1.
- Each is a 64-bit counter that wraps from all-ones to 0.
- A CSR write to either half in the same cycle wins over the increment for the whole 64-bit value: the written half takes the new data and the other half holds.

FSM with states RUN, TRAP, RET; RUN is the reset state.
- RUN: trap_i -> TRAP; else mret_i -> RET.
- TRAP (1 cycle) does all of:
  - mepc <= captured trap_pc
  - mcause <= captured cause
  - MPIE <= MIE, MIE <= 0
  - redirect_o=1, redirect_pc_o = vector
  - return to RUN.
- RET (1 cycle) does all of:
  - MIE <= MPIE, MPIE <= 1
  - redirect_o=1, redirect_pc_o = mepc
  - return to RUN.
- The trap inputs are captured in RUN on the cycle trap_i is high.
- irq_take_o = MIE & ((MEIE&irq_ext_i) | (MTIE&irq_timer_i)), registered, forced 0 outside RUN. The pipeline answers by raising trap_i with cause 0x8000000B (external; has priority) or 0x80000007 (timer).

Simultaneous events:
- trap_i and mret_i in the same cycle: trap wins and mret is dropped.
- trap_i and a CSR write in the same cycle: the CSR write is discarded.
- A CSR op while in TRAP/RET is ignored and csr_illegal_o=0. The pipeline guarantees it stalls.
- trap_i while in TRAP/RET is ignored.

Reset mid-sequence: the FSM returns to RUN immediately and no redirect is issued.

Optional Feature:
CSR_VECTORED_EN
- Defined:
  - mtvec[1:0] MODE is writable; values 00 and 01 are legal, others write as 00.
  - For an interrupt cause with MODE=01: vector = {mtvec[31:2],2'b00} + 4*cause[30:0].
  - Otherwise vector = the base.
- Undefined: mtvec[1:0] are hardwired 0 and all traps go to the base.

Decomposition:
- Package csr_pkg holds:
  - CSR address localparams
  - csr_op_e enum (NONE/RW/RS/RC)
  - fsm state enum
  - cause constants (CAUSE_IRQ_EXT, CAUSE_IRQ_TIMER, CAUSE_ILLEGAL=2, CAUSE_ECALL=11)
  - mstatus/mie bit index constants
- Sub-module csr_counter64: 64-bit counter with inc_i, wr_lo_i, wr_hi_i, wdata_i, q_o. Instantiated twice, for mcycle and minstret.

Test Plan:
- Reset, then read 0xF14, 0x301, 0x305 -> HART_ID, MISA_VAL, MTVEC_RESET; read 0x7C0 -> illegal=1, rdata=0.
- mstatus=0x8 (RW), then RS 0x80 -> mstatus reads 0x88; RC 0x8 -> 0x80; write 0xF11 -> illegal=1, value unchanged.
- mtvec=0x1000, mstatus.MIE=1, trap_i with cause=2, pc=0x2003 -> next cycle redirect_o=1, pc=0x1000; then mepc=0x2000, mcause=2, mstatus=0x80.
- mret_i after the trap -> redirect_pc_o=0x2000; mstatus=0x88.
- With CSR_VECTORED_EN, mtvec=0x1001, MIE=MTIE=1, irq_timer_i=1 -> irq_take_o=1; trap cause 0x80000007 -> redirect_pc_o=0x101C.
- Write mcycle=0xFFFFFFFF, mcycleh=0 -> after one cycle mcycleh=1, mcycle=0; write during increment -> written value read back exactly.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR/trap unit: CSR addresses, op and
// state encodings, cause codes and mstatus/mie bit positions.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS    = 12'h300;
  localparam logic [11:0] CSR_MISA       = 12'h301;
  localparam logic [11:0] CSR_MIE        = 12'h304;
  localparam logic [11:0] CSR_MTVEC      = 12'h305;
  localparam logic [11:0] CSR_MCOUNTEREN = 12'h306;
  localparam logic [11:0] CSR_MEPC       = 12'h341;
  localparam logic [11:0] CSR_MCAUSE     = 12'h342;
  localparam logic [11:0] CSR_MIP        = 12'h344;
  localparam logic [11:0] CSR_MCYCLE     = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET   = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH    = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH  = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID  = 12'hF11;
  localparam logic [11:0] CSR_MARCHID    = 12'hF12;
  localparam logic [11:0] CSR_MIMPID     = 12'hF13;
  localparam logic [11:0] CSR_MHARTID    = 12'hF14;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_TRAP,
    ST_RET
  } state_e;

  localparam logic [31:0] CAUSE_IRQ_EXT   = 32'h8000_000B;
  localparam logic [31:0] CAUSE_IRQ_TIMER = 32'h8000_0007;
  localparam logic [31:0] CAUSE_ILLEGAL   = 32'd2;
  localparam logic [31:0] CAUSE_ECALL     = 32'd11;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;
  localparam int unsigned MIE_MEIE     = 11;
  localparam int unsigned MIE_MTIE     = 7;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves;
// a write to either half takes precedence over the increment.
module csr_counter64 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] q_o
);

  logic [63:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i)      cnt_d[31:0]  = wdata_i;
    else if (wr_hi_i) cnt_d[63:32] = wdata_i;
    else if (inc_i)   cnt_d        = cnt_q + 64'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign q_o = cnt_q;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with trap entry / MRET sequencing and interrupt gating.
// Optional CSR_VECTORED_EN enables mtvec MODE and vectored interrupt dispatch.
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     HART_ID     = 0,
  parameter logic [XLEN-1:0] MISA_VAL    = 32'h4000_0100,
  parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [1:0]      csr_op_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_illegal_o,
  input  logic            instret_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            mret_i,
  input  logic            irq_ext_i,
  input  logic            irq_timer_i,
  output logic            irq_take_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  state_e          state_q, state_d;
  csr_op_e         op;
  logic            mstatus_mie_q, mstatus_mie_d, mstatus_mpie_q, mstatus_mpie_d;
  logic            meie_q, mtie_q, irq_take_q, irq_take_d;
  logic [XLEN-1:0] mtvec_q, mcounteren_q, mepc_q, mcause_q, cause_q;
  logic [XLEN-1:2] tpc_q;
  logic [63:0]     mcycle, minstret;
  logic [XLEN-1:0] rdata_raw, wval, vector;
  logic            csr_known, wr_attempt, in_run, csr_we;

  assign op     = csr_op_e'(csr_op_i);
  assign in_run = (state_q == ST_RUN);

  always_comb begin
    csr_known = 1'b1;
    rdata_raw = '0;
    case (csr_addr_i)
      CSR_MISA:       rdata_raw = MISA_VAL;
      CSR_MVENDORID,
      CSR_MARCHID,
      CSR_MIMPID:     rdata_raw = '0;
      CSR_MHARTID:    rdata_raw = XLEN'(HART_ID);
      CSR_MSTATUS: begin
        rdata_raw[MSTATUS_MIE]  = mstatus_mie_q;
        rdata_raw[MSTATUS_MPIE] = mstatus_mpie_q;
      end
      CSR_MIE: begin
        rdata_raw[MIE_MEIE] = meie_q;
        rdata_raw[MIE_MTIE] = mtie_q;
      end
      CSR_MTVEC:      rdata_raw = mtvec_q;
      CSR_MCOUNTEREN: rdata_raw = mcounteren_q;
      CSR_MEPC:       rdata_raw = mepc_q;
      CSR_MCAUSE:     rdata_raw = mcause_q;
      CSR_MIP: begin
        rdata_raw[MIE_MEIE] = irq_ext_i;
        rdata_raw[MIE_MTIE] = irq_timer_i;
      end
      CSR_MCYCLE:     rdata_raw = mcycle[31:0];
      CSR_MCYCLEH:    rdata_raw = mcycle[63:32];
      CSR_MINSTRET:   rdata_raw = minstret[31:0];
      CSR_MINSTRETH:  rdata_raw = minstret[63:32];
      default:        csr_known = 1'b0;
    endcase
  end

  // RS/RC with a zero operand are pure reads, so they never trip the read-only check.
  assign wr_attempt    = (op == CSR_RW) || ((op == CSR_RS || op == CSR_RC) && (|csr_wdata_i));
  assign csr_illegal_o = in_run && (op != CSR_NONE) &&
                         (!csr_known || (wr_attempt && csr_addr_i[11:10] == 2'b11));
  assign csr_rdata_o   = csr_illegal_o ? '0 : rdata_raw;
  assign csr_we        = in_run && wr_attempt && !csr_illegal_o && !trap_i;

  always_comb begin
    case (op)
      CSR_RW:  wval = csr_wdata_i;
      CSR_RS:  wval = rdata_raw | csr_wdata_i;
      CSR_RC:  wval = rdata_raw & ~csr_wdata_i;
      default: wval = rdata_raw;
    endcase
  end

`ifdef CSR_VECTORED_EN
  assign vector = (cause_q[XLEN-1] && mtvec_q[1:0] == 2'b01)
                ? {mtvec_q[XLEN-1:2], 2'b00} + {cause_q[XLEN-3:0], 2'b00}
                : {mtvec_q[XLEN-1:2], 2'b00};
`else
  assign vector = {mtvec_q[XLEN-1:2], 2'b00};
`endif

  always_comb begin
    state_d        = state_q;
    redirect_o     = 1'b0;
    redirect_pc_o  = '0;
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    case (state_q)
      ST_RUN: begin
        if (trap_i)      state_d = ST_TRAP;
        else if (mret_i) state_d = ST_RET;
        if (csr_we && csr_addr_i == CSR_MSTATUS) begin
          mstatus_mie_d  = wval[MSTATUS_MIE];
          mstatus_mpie_d = wval[MSTATUS_MPIE];
        end
      end
      ST_TRAP: begin
        state_d        = ST_RUN;
        redirect_o     = 1'b1;
        redirect_pc_o  = vector;
        mstatus_mpie_d = mstatus_mie_q;
        mstatus_mie_d  = 1'b0;
      end
      ST_RET: begin
        state_d        = ST_RUN;
        redirect_o     = 1'b1;
        redirect_pc_o  = mepc_q;
        mstatus_mie_d  = mstatus_mpie_q;
        mstatus_mpie_d = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Built from next-state MIE so the cycle after trap entry cannot see a stale enable.
  assign irq_take_d = (state_d == ST_RUN) && mstatus_mie_d &&
                      ((meie_q && irq_ext_i) || (mtie_q && irq_timer_i));
  assign irq_take_o = irq_take_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_RUN;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      meie_q         <= 1'b0;
      mtie_q         <= 1'b0;
`ifdef CSR_VECTORED_EN
      mtvec_q        <= MTVEC_RESET;
`else
      mtvec_q        <= {MTVEC_RESET[XLEN-1:2], 2'b00};
`endif
      mcounteren_q   <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      cause_q        <= '0;
      tpc_q          <= '0;
      irq_take_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      irq_take_q     <= irq_take_d;
      if (in_run && trap_i) begin
        cause_q <= trap_cause_i;
        tpc_q   <= trap_pc_i[XLEN-1:2];
      end
      if (state_q == ST_TRAP) begin
        mepc_q   <= {tpc_q, 2'b00};
        mcause_q <= cause_q;
      end
      if (csr_we) begin
        case (csr_addr_i)
          CSR_MIE: begin
            meie_q <= wval[MIE_MEIE];
            mtie_q <= wval[MIE_MTIE];
          end
`ifdef CSR_VECTORED_EN
          CSR_MTVEC:      mtvec_q <= {wval[XLEN-1:2], (wval[1:0] == 2'b01) ? 2'b01 : 2'b00};
`else
          CSR_MTVEC:      mtvec_q <= {wval[XLEN-1:2], 2'b00};
`endif
          CSR_MCOUNTEREN: mcounteren_q <= wval;
          CSR_MEPC:       mepc_q <= {wval[XLEN-1:2], 2'b00};
          CSR_MCAUSE:     mcause_q <= wval;
          default: ;
        endcase
      end
    end
  end

  csr_counter64 u_mcycle (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (1'b1),
    .wr_lo_i (csr_we && csr_addr_i == CSR_MCYCLE),
    .wr_hi_i (csr_we && csr_addr_i == CSR_MCYCLEH),
    .wdata_i (wval),
    .q_o     (mcycle)
  );

  csr_counter64 u_minstret (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (instret_i),
    .wr_lo_i (csr_we && csr_addr_i == CSR_MINSTRET),
    .wr_hi_i (csr_we && csr_addr_i == CSR_MINSTRETH),
    .wdata_i (wval),
    .q_o     (minstret)
  );

endmodule

// File: tb/tb_csr_trap_unit.sv
// Scoreboard bench for csr_trap_unit: the driver queues expected outputs per
// cycle, the monitor pops and compares them mid-cycle on the falling edge.
module tb_csr_trap_unit;
  import csr_pkg::*;

  localparam int unsigned HART = 3;
`ifdef CSR_VECTORED_EN
  localparam logic [31:0] MTV_RB = 32'h1001;
  localparam logic [31:0] VEC_T  = 32'h101C;
`else
  localparam logic [31:0] MTV_RB = 32'h1000;
  localparam logic [31:0] VEC_T  = 32'h1000;
`endif

  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic [11:0] csr_addr_i = '0;
  logic [1:0]  csr_op_i = '0;
  logic [31:0] csr_wdata_i = '0, trap_cause_i = '0, trap_pc_i = '0;
  logic        instret_i = 1'b0, trap_i = 1'b0, mret_i = 1'b0;
  logic        irq_ext_i = 1'b0, irq_timer_i = 1'b0;
  logic [31:0] csr_rdata_o, redirect_pc_o;
  logic        csr_illegal_o, irq_take_o, redirect_o;

  csr_trap_unit #(.XLEN(32), .HART_ID(HART)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .csr_addr_i(csr_addr_i), .csr_op_i(csr_op_i),
    .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
    .instret_i(instret_i), .trap_i(trap_i), .trap_cause_i(trap_cause_i),
    .trap_pc_i(trap_pc_i), .mret_i(mret_i), .irq_ext_i(irq_ext_i),
    .irq_timer_i(irq_timer_i), .irq_take_o(irq_take_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc_n = 0;
  always @(posedge clk_i) cyc_n <= cyc_n + 1;

  typedef enum int {S_RDATA, S_ILL, S_REDIR, S_RPC, S_IRQ} sel_e;
  typedef struct {
    int unsigned cyc;
    sel_e        sel;
    logic [31:0] exp;
    string       tag;
  } sb_t;
  sb_t sb[$];
  int n_cmp = 0, n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void expect_at(input sel_e s, input logic [31:0] e, input string tag);
    sb.push_back('{cyc_n, s, e, tag});
  endfunction

  initial begin
    sb_t         e;
    logic [31:0] obs;
    forever begin
      @(negedge clk_i);
      while (sb.size() > 0 && sb[0].cyc <= cyc_n) begin
        e = sb.pop_front();
        case (e.sel)
          S_RDATA: obs = csr_rdata_o;
          S_ILL:   obs = {31'b0, csr_illegal_o};
          S_REDIR: obs = {31'b0, redirect_o};
          S_RPC:   obs = redirect_pc_o;
          default: obs = {31'b0, irq_take_o};
        endcase
        if (e.cyc != cyc_n) check_val({e.tag, "_late"}, cyc_n, e.cyc);
        else                check_val(e.tag, obs, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic nxt();
    @(posedge clk_i);
    #1;
    csr_op_i = 2'b00; csr_addr_i = '0; csr_wdata_i = '0;
    trap_i = 1'b0; mret_i = 1'b0; instret_i = 1'b0;
  endtask

  task automatic op_at(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
    csr_op_i = op; csr_addr_i = a; csr_wdata_i = wd;
  endtask

  task automatic acc(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                     input logic [31:0] erd, input logic eill, input string tag);
    op_at(op, a, wd);
    expect_at(S_RDATA, erd, {tag, "_rd"});
    expect_at(S_ILL, {31'b0, eill}, {tag, "_ill"});
    nxt();
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
    acc(2'b10, a, 32'h0, exp, 1'b0, tag);
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // reset state and constant CSRs
    expect_at(S_REDIR, 0, "rst_redir");
    expect_at(S_RPC, 0, "rst_rpc");
    expect_at(S_IRQ, 0, "rst_irq");
    rd(12'hF14, HART, "mhartid");
    rd(12'h301, 32'h4000_0100, "misa");
    rd(12'h305, 32'h0, "mtvec_rst");
    acc(2'b10, 12'h7C0, 32'h0, 32'h0, 1'b1, "unimpl");

    // read/modify/write on mstatus, read-only protection
    acc(2'b01, 12'h300, 32'h8, 32'h0, 1'b0, "mstatus_rw");
    rd(12'h300, 32'h8, "mstatus_8");
    acc(2'b10, 12'h300, 32'h80, 32'h8, 1'b0, "mstatus_rs");
    rd(12'h300, 32'h88, "mstatus_88");
    acc(2'b11, 12'h300, 32'h8, 32'h88, 1'b0, "mstatus_rc");
    rd(12'h300, 32'h80, "mstatus_80");
    acc(2'b01, 12'hF11, 32'h5, 32'h0, 1'b1, "ro_write");
    rd(12'hF11, 32'h0, "ro_read");
    acc(2'b10, 12'hF14, 32'h1, 32'h0, 1'b1, "ro_set");

    // synchronous trap with concurrent CSR write and MRET
    acc(2'b01, 12'h305, 32'h1000, 32'h0, 1'b0, "mtvec_wr");
    acc(2'b10, 12'h300, 32'h8, 32'h80, 1'b0, "mie_on");
    op_at(2'b01, 12'h306, 32'hFFFF);
    trap_i = 1'b1; trap_cause_i = 32'd2; trap_pc_i = 32'h2003; mret_i = 1'b1;
    expect_at(S_ILL, 0, "trap_csr_ill");
    expect_at(S_REDIR, 0, "trap_req_redir");
    nxt();
    op_at(2'b01, 12'h7C0, 32'h1);
    expect_at(S_ILL, 0, "busy_ill");
    expect_at(S_REDIR, 1, "trap_redir");
    expect_at(S_RPC, 32'h1000, "trap_pc");
    nxt();
    expect_at(S_REDIR, 0, "post_trap_redir");
    rd(12'h341, 32'h2000, "mepc");
    rd(12'h342, 32'h2, "mcause");
    rd(12'h300, 32'h80, "mstatus_trap");
    rd(12'h306, 32'h0, "mcounteren_drop");

    // MRET
    mret_i = 1'b1;
    expect_at(S_REDIR, 0, "mret_req");
    nxt();
    expect_at(S_REDIR, 1, "mret_redir");
    expect_at(S_RPC, 32'h2000, "mret_pc");
    nxt();
    rd(12'h300, 32'h88, "mstatus_mret");

    // timer interrupt
    acc(2'b01, 12'h305, 32'h1001, 32'h1000, 1'b0, "mtvec_mode");
    rd(12'h305, MTV_RB, "mtvec_rb");
    acc(2'b01, 12'h304, 32'h80, 32'h0, 1'b0, "mie_wr");
    irq_timer_i = 1'b1;
    expect_at(S_IRQ, 0, "irq_lat");
    nxt();
    expect_at(S_IRQ, 1, "irq_take");
    trap_i = 1'b1; trap_cause_i = CAUSE_IRQ_TIMER; trap_pc_i = 32'h3000;
    nxt();
    expect_at(S_IRQ, 0, "irq_in_trap");
    expect_at(S_REDIR, 1, "irq_redir");
    expect_at(S_RPC, VEC_T, "irq_vector");
    nxt();
    expect_at(S_IRQ, 0, "irq_masked");
    rd(12'h342, CAUSE_IRQ_TIMER, "irq_mcause");
    rd(12'h341, 32'h3000, "irq_mepc");
    irq_ext_i = 1'b1;
    rd(12'h344, 32'h880, "mip");
    irq_ext_i = 1'b0; irq_timer_i = 1'b0;
    rd(12'h344, 32'h0, "mip_clr");

    // 64-bit counters
    op_at(2'b01, 12'hB00, 32'hFFFF_FFFF); expect_at(S_ILL, 0, "mcycle_wr_ill"); nxt();
    op_at(2'b01, 12'hB80, 32'h0);         expect_at(S_ILL, 0, "mcycleh_wr_ill"); nxt();
    rd(12'hB00, 32'hFFFF_FFFF, "mcycle_pre");
    rd(12'hB00, 32'h0, "mcycle_wrap");
    rd(12'hB80, 32'h1, "mcycleh_carry");
    op_at(2'b01, 12'hB00, 32'h1234); nxt();
    rd(12'hB00, 32'h1234, "mcycle_wr_wins");
    op_at(2'b01, 12'hB02, 32'h5); instret_i = 1'b1; nxt();
    instret_i = 1'b1;
    rd(12'hB02, 32'h5, "minstret_pre");
    rd(12'hB02, 32'h6, "minstret_inc");
    rd(12'hB02, 32'h6, "minstret_hold");
    op_at(2'b01, 12'hB82, 32'h7); instret_i = 1'b1; nxt();
    rd(12'hB82, 32'h7, "minstreth_wr");
    rd(12'hB02, 32'h6, "minstret_lo_held");
    acc(2'b01, 12'h341, 32'h1237, 32'h3000, 1'b0, "mepc_wr");
    rd(12'h341, 32'h1234, "mepc_align");

    // reset while in TRAP
    trap_i = 1'b1; trap_cause_i = CAUSE_ECALL; trap_pc_i = 32'h4000;
    nxt();
    rst_i = 1'b1;
    expect_at(S_REDIR, 0, "midrst_redir");
    expect_at(S_RPC, 0, "midrst_rpc");
    nxt();
    rst_i = 1'b0;
    rd(12'h300, 32'h0, "midrst_mstatus");
    rd(12'h341, 32'h0, "midrst_mepc");
    expect_at(S_REDIR, 0, "midrst_quiet");
    nxt();
    nxt();

    check_val("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
